// File: rtl/cell_link_pkg.sv
// Shared constants for the PIC cell-voltage serial link: FSM encodings and timing defaults.
package cell_link_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // 50 MHz / 9600 baud
  localparam logic [15:0] CLKS_PER_BIT_DEFAULT = 16'd5208;
  // 0.5 s at 50 MHz
  localparam logic [24:0] STALE_CYCLES_DEFAULT = 25'd25_000_000;

  function automatic logic [15:0] half_bit_reload(input logic [15:0] cpb);
    return (cpb >> 1) - 16'd1;
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cell_voltage_rx.sv
// 8N1 UART receiver for one PIC cell-voltage line with framing-error pulse and stale-link watchdog.
module cell_voltage_rx
  import cell_link_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [24:0] STALE_CYCLES = STALE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] vc_out,
  output logic       vc_valid,
  output logic       frame_err,
  output logic       stale
);

  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [24:0] stale_cnt;
  logic [24:0] stale_cnt_next;
  logic        byte_ok;

  rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign byte_ok = (state == ST_STOP) && (baud_cnt == '0) && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      vc_out    <= '0;
      vc_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vc_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            baud_cnt <= half_bit_reload(CLKS_PER_BIT);
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              baud_cnt <= CLKS_PER_BIT - 16'd1;
              bit_idx  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= CLKS_PER_BIT - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            baud_cnt <= '0;
            if (rx_s) begin
              vc_out   <= shreg;
              vc_valid <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stale_cnt_next = stale_cnt;
    if (stale_cnt != STALE_CYCLES) begin
      stale_cnt_next = stale_cnt + 25'd1;
    end
  end

  // stale is sticky: after reset the link counts as silent until the first good byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      stale_cnt <= '0;
      stale     <= 1'b1;
    end else if (byte_ok) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else begin
      stale_cnt <= stale_cnt_next;
      stale     <= stale | (stale_cnt_next == STALE_CYCLES);
    end
  end

endmodule

// File: doc/cell_voltage_rx.md
Name: cell_voltage_rx

Overview:
- Single-clock UART receiver for one PIC cell-voltage serial line (8N1, LSB first) running on the 50 MHz system clock.
- Feeds the per-cell averaging stage: one decoded voltage byte plus a one-cycle valid strobe.
- Adds framing-error detection and a stale-data watchdog, so the overvoltage and switching interlock can block firing when a PIC link goes silent.

Parameters:
- CLKS_PER_BIT, 16'd5208: system clocks per bit (50 MHz / 9600 baud); minimum 4, must be even.
- STALE_CYCLES, 25'd25_000_000: clocks without a valid byte before stale asserts (0.5 s).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  raw serial line from the PIC fibre receiver; asynchronous; idle high.
- vc_out  out  8  last correctly framed voltage byte.
- vc_valid  out  1  one-cycle pulse; vc_out updated in the same cycle.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- stale  out  1  high while no valid byte has arrived for STALE_CYCLES clocks.

Behaviour:
- Reset: synchronous on posedge clk when rst=1. Values after reset:
  - vc_out=0, vc_valid=0, frame_err=0, stale=1.
  - FSM=IDLE, synchronizer flops=1, all counters=0.
- Input path: 2-flop synchronizer on rx_in; rx_s is the second flop. All decisions use rx_s only.
- Counters:
  - baud_cnt: 16 bits, counts down, reloaded on each state entry.
  - bit_idx: 3 bits.
  - shift register: 8 bits; each new sample shifts in at the MSB, so the first bit received (LSB) lands in bit 0 after 8 shifts.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s=0, go to START and load baud_cnt=CLKS_PER_BIT/2-1.
  - START: when baud_cnt reaches 0, sample rx_s (mid-bit).
    - rx_s=1: glitch; return to IDLE, no pulses.
    - rx_s=0: go to DATA with baud_cnt=CLKS_PER_BIT-1 and bit_idx=0.
  - DATA: at each baud_cnt=0, shift rx_s in and reload baud_cnt. After bit_idx=7 is sampled, go to STOP; otherwise increment bit_idx.
  - STOP: at baud_cnt=0, sample rx_s.
    - rx_s=1: vc_out<=shift register, vc_valid=1 for the next cycle, go to IDLE.
    - rx_s=0: frame_err=1 for the next cycle, vc_out unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents re-triggering inside a break or misaligned frame.
- Latency: vc_valid rises exactly 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling edge at rx_in. The breakdown is 2 synchronizer cycles, then the half-bit to mid-start, then 8 data bits plus the stop bit, then 1 output register.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE is entered at mid-stop, so the next falling edge is detected normally.
- Watchdog:
  - stale_cnt: 25 bits, increments every cycle and saturates at STALE_CYCLES.
  - stale = (stale_cnt == STALE_CYCLES), registered.
  - On vc_valid, stale_cnt clears to 0 and stale drops the same cycle as vc_valid.
  - frame_err does not clear the watchdog.
- Simultaneous events: when vc_valid and saturation coincide, the clear wins.
- vc_valid and frame_err are mutually exclusive.
- Reset mid-frame: partial data is discarded, no pulse is emitted, and the FSM is in IDLE on the next cycle.

Decomposition:
- Shared package (cell_link_pkg):
  - state encoding constants for IDLE, START, DATA, STOP, WAIT_IDLE;
  - default CLKS_PER_BIT for 9600 baud at 50 MHz;
  - STALE_CYCLES default.
- One natural sub-module, rx_sync2: the 2-flop synchronizer, reset to 1. Everything else is flat.

Test Plan (CLKS_PER_BIT=16, STALE_CYCLES=1000):
1. Send 8N1 byte 0xA5 after reset. Required response:
   - vc_out=0xA5 with a single vc_valid pulse exactly 155 cycles after the start-bit falling edge;
   - stale goes 1 to 0 on that cycle.
2. Send 0x00, 0xFF, then 0xE6 (230) back-to-back with no idle gap. Required response: three vc_valid pulses, with vc_out=0x00, then 0xFF, then 0xE6, spaced exactly 160 cycles apart.
3. Drive a 5-cycle low glitch on rx_in while idle. Required response: no vc_valid, no frame_err, FSM back in IDLE.
4. Send 0x3C with the stop bit forced low, holding rx_in low 40 more cycles before releasing it, then send 0x12. Required response:
   - one frame_err pulse and vc_out stays at its prior value;
   - nothing fires during the low hold;
   - 0x12 is then received correctly.
5. After a valid byte, keep the line idle. Required response: stale asserts exactly 1000 cycles after the vc_valid cycle and holds; the next valid byte clears it.
6. Assert rst for 1 cycle during DATA bit 4 of a frame. Required response:
   - outputs return to reset values, stale=1;
   - the remaining bits of that frame produce no vc_valid;
   - the next full frame 0x7E decodes correctly.
